// File: rtl/tb_assert_sched_if.sv
// Checker result handshake bundle: one valid/pass/ready lane per checker.
interface tb_assert_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_pass;
   logic [NREQ-1:0] req_ready;

   modport master (
      output req_valid,
      output req_pass,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_pass,
      output req_ready
   );
endinterface

// File: rtl/tb_assert_sched.sv
// Check-result scheduler: round-robin grants one checker result per cycle,
// keeps saturating totals, and sequences RUN -> DRAIN -> DONE with a single
// finish pulse toward the testbench top.
module tb_assert_sched #(
   parameter int NREQ = 4,
   parameter int CW = 16,
   parameter bit DIE_ON_FAIL = 1'b0,
   localparam int IW = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   tb_assert_sched_if.slave     req,
   input  logic                 end_req,
   output logic [CW-1:0]        tot_cnt,
   output logic [CW-1:0]        pass_cnt,
   output logic [CW-1:0]        fail_cnt,
   output logic                 first_fail_vld,
   output logic [IW-1:0]        first_fail_id,
   output logic                 finish_req,
   output logic                 done,
   output logic                 verdict_ok
);

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = '1;

   state_t          state;
   state_t          state_next;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   grant_id;
   logic            grant_found;
   logic [IW:0]     cand;
   logic [NREQ-1:0] ready;
   logic            accept_fail;
   logic [CW-1:0]   tot_next;
   logic [CW-1:0]   pass_next;
   logic [CW-1:0]   fail_next;

   // Round-robin search: first valid requester at or after ptr, wrapping; no grants once DONE.
   always_comb begin
      ready       = '0;
      grant_id    = '0;
      grant_found = 1'b0;
      cand        = '0;
      if (state != S_DONE) begin
         for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) begin
               cand = cand - (IW+1)'(NREQ);
            end
            if (!grant_found && req.req_valid[cand[IW-1:0]]) begin
               grant_found = 1'b1;
               grant_id    = cand[IW-1:0];
            end
         end
      end
      ready[grant_id] = grant_found;
   end

   assign req.req_ready = ready;
   assign accept_fail   = grant_found & ~req.req_pass[grant_id];
   assign done          = (state == S_DONE);

   // Saturating next values of the result counters; each counter stops at its own maximum.
   always_comb begin
      tot_next  = tot_cnt;
      pass_next = pass_cnt;
      fail_next = fail_cnt;
      if (grant_found) begin
         if (tot_cnt != CNT_MAX) begin
            tot_next = tot_cnt + CW'(1);
         end
         if (accept_fail) begin
            if (fail_cnt != CNT_MAX) begin
               fail_next = fail_cnt + CW'(1);
            end
         end else if (pass_cnt != CNT_MAX) begin
            pass_next = pass_cnt + CW'(1);
         end
      end
   end

   // Phase sequencing: a die-on-fail stop outranks the end request; drain ends on the first idle cycle.
   always_comb begin
      state_next = state;
      case (state)
         S_RUN: begin
            if (DIE_ON_FAIL && accept_fail) begin
               state_next = S_DONE;
            end else if (end_req) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (DIE_ON_FAIL && accept_fail) begin
               state_next = S_DONE;
            end else if (req.req_valid == '0) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_DONE;
         end
         default: begin
            state_next = S_RUN;
         end
      endcase
   end

   // Phase register; DONE is left only through reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Counters, arbitration pointer, first-fail capture and the registered finish/verdict flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         tot_cnt        <= '0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         ptr            <= '0;
         first_fail_vld <= 1'b0;
         first_fail_id  <= '0;
         finish_req     <= 1'b0;
         verdict_ok     <= 1'b0;
      end else begin
         tot_cnt    <= tot_next;
         pass_cnt   <= pass_next;
         fail_cnt   <= fail_next;
         finish_req <= (state != S_DONE) && (state_next == S_DONE);
         verdict_ok <= (state_next == S_DONE) && (fail_next == '0) && (tot_next != '0);
         if (grant_found) begin
            ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
         end
         if (accept_fail && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_id  <= grant_id;
         end
      end
   end

endmodule

// File: tb/tb_tb_assert_sched.sv
// Self-checking bench for tb_assert_sched: one DIE_ON_FAIL=0 instance with
// 4-bit counters and one DIE_ON_FAIL=1 instance with 16-bit counters.
module tb_tb_assert_sched;

   localparam int NREQ = 4;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] pass;
      logic       end_r;
      logic [3:0] exp_ready;
      logic       exp_finish;
      logic       exp_done;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_a;
   logic        reset_b;
   logic        end_req;
   logic [3:0]  valid;
   logic [3:0]  pass;
   bit          active_b;

   logic [3:0]  tot_a, pass_a, fail_a;
   logic        ffv_a, finish_a, done_a, verdict_a;
   logic [1:0]  ffid_a;
   logic [15:0] tot_b, pass_b, fail_b;
   logic        ffv_b, finish_b, done_b, verdict_b;
   logic [1:0]  ffid_b;

   int checks = 0;
   int errors = 0;
   int sb[$];
   vec_t tbl[11];

   always #5 clk = ~clk;

   tb_assert_sched_if #(.NREQ(NREQ)) ifa ();
   tb_assert_sched_if #(.NREQ(NREQ)) ifb ();

   assign ifa.req_valid = valid;
   assign ifa.req_pass  = pass;
   assign ifb.req_valid = valid;
   assign ifb.req_pass  = pass;

   tb_assert_sched #(.NREQ(NREQ), .CW(4), .DIE_ON_FAIL(1'b0)) dut_a (
      .clk            (clk),
      .reset          (reset_a),
      .req            (ifa),
      .end_req        (end_req),
      .tot_cnt        (tot_a),
      .pass_cnt       (pass_a),
      .fail_cnt       (fail_a),
      .first_fail_vld (ffv_a),
      .first_fail_id  (ffid_a),
      .finish_req     (finish_a),
      .done           (done_a),
      .verdict_ok     (verdict_a)
   );

   tb_assert_sched #(.NREQ(NREQ), .CW(16), .DIE_ON_FAIL(1'b1)) dut_b (
      .clk            (clk),
      .reset          (reset_b),
      .req            (ifb),
      .end_req        (end_req),
      .tot_cnt        (tot_b),
      .pass_cnt       (pass_b),
      .fail_cnt       (fail_b),
      .first_fail_vld (ffv_b),
      .first_fail_id  (ffid_b),
      .finish_req     (finish_b),
      .done           (done_b),
      .verdict_ok     (verdict_b)
   );

   function automatic logic [3:0] onehot(input int i);
      logic [3:0] v;
      v = 4'b0001;
      return v << i;
   endfunction

   function automatic vec_t mkVec(input logic [3:0] v, input logic [3:0] p, input logic e,
                                  input logic [3:0] r, input logic f, input logic d);
      vec_t x;
      x.valid = v; x.pass = p; x.end_r = e; x.exp_ready = r; x.exp_finish = f; x.exp_done = d;
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expectGrant(input int id);
      sb.push_back(id);
   endtask

   // Drive one cycle at a falling edge, check ready and any handshake, then advance to the next falling edge.
   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] p, input logic e,
                                input logic [3:0] exp_ready);
      logic [3:0] rdy;
      logic [3:0] hs;
      logic       in_reset;
      int         act_id;
      valid = v;
      pass  = p;
      end_req = e;
      #1;
      rdy      = active_b ? ifb.req_ready : ifa.req_ready;
      in_reset = active_b ? reset_b : reset_a;
      checkOutput("req_ready", 32'(rdy), 32'(exp_ready));
      hs = v & rdy;
      if (hs != 4'b0 && !in_reset) begin
         act_id = 0;
         for (int i = 0; i < 4; i++) begin
            if (hs[i]) act_id = i;
         end
         if (sb.size() == 0) checkOutput("unexpected_accept", 32'(hs), 32'd0);
         else checkOutput("grant_id", act_id, sb.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic checkState(input int tot, input int pas, input int fl, input int ffv,
                             input int ffid, input int fin, input int dn, input int vok);
      if (active_b) begin
         checkOutput("tot_cnt", 32'(tot_b), tot);
         checkOutput("pass_cnt", 32'(pass_b), pas);
         checkOutput("fail_cnt", 32'(fail_b), fl);
         checkOutput("first_fail_vld", 32'(ffv_b), ffv);
         checkOutput("first_fail_id", 32'(ffid_b), ffid);
         checkOutput("finish_req", 32'(finish_b), fin);
         checkOutput("done", 32'(done_b), dn);
         checkOutput("verdict_ok", 32'(verdict_b), vok);
      end else begin
         checkOutput("tot_cnt", 32'(tot_a), tot);
         checkOutput("pass_cnt", 32'(pass_a), pas);
         checkOutput("fail_cnt", 32'(fail_a), fl);
         checkOutput("first_fail_vld", 32'(ffv_a), ffv);
         checkOutput("first_fail_id", 32'(ffid_a), ffid);
         checkOutput("finish_req", 32'(finish_a), fin);
         checkOutput("done", 32'(done_a), dn);
         checkOutput("verdict_ok", 32'(verdict_a), vok);
      end
   endtask

   task automatic doReset();
      reset_a = 1'b1;
      reset_b = 1'b1;
      applyStimulus(4'h0, 4'h0, 1'b0, 4'h0);
      applyStimulus(4'h0, 4'h0, 1'b0, 4'h0);
      reset_a = active_b;
      reset_b = !active_b;
      sb.delete();
      checkState(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Bound the whole run so a stuck design still produces a verdict.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      valid = '0; pass = '0; end_req = 1'b0;
      reset_a = 1'b1; reset_b = 1'b1; active_b = 1'b0;

      for (int i = 0; i < 8; i++) tbl[i] = mkVec(4'hF, 4'hF, 1'b0, onehot(i % 4), 1'b0, 1'b0);
      tbl[8]  = mkVec(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
      tbl[9]  = mkVec(4'h0, 4'hF, 1'b0, 4'h0, 1'b1, 1'b1);
      tbl[10] = mkVec(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1);

      @(negedge clk);

      $display("[TB] all-pass round robin and end of test");
      doReset();
      for (int i = 0; i < 11; i++) begin
         for (int b = 0; b < 4; b++) begin
            if (tbl[i].exp_ready[b]) expectGrant(b);
         end
         applyStimulus(tbl[i].valid, tbl[i].pass, tbl[i].end_r, tbl[i].exp_ready);
         checkOutput("vec_finish_req", 32'(finish_a), 32'(tbl[i].exp_finish));
         checkOutput("vec_done", 32'(done_a), 32'(tbl[i].exp_done));
      end
      checkState(8, 8, 0, 0, 0, 0, 1, 1);
      checkOutput("sb_empty", sb.size(), 0);

      $display("[TB] single fail from requester 2 without die");
      doReset();
      for (int i = 0; i < 10; i++) begin
         expectGrant(i % 4);
         applyStimulus(4'hF, (i == 6) ? 4'b1011 : 4'hF, 1'b0, onehot(i % 4));
      end
      applyStimulus(4'h0, 4'hF, 1'b1, 4'h0);
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0);
      checkState(10, 9, 1, 1, 2, 1, 1, 0);
      checkOutput("sb_empty", sb.size(), 0);

      $display("[TB] die on fail coinciding with end request");
      active_b = 1'b1;
      doReset();
      for (int i = 0; i < 3; i++) begin
         expectGrant(i);
         applyStimulus(4'hF, 4'hF, 1'b0, onehot(i));
      end
      checkState(3, 3, 0, 0, 0, 0, 0, 0);
      expectGrant(3);
      applyStimulus(4'hF, 4'b0111, 1'b1, 4'b1000);
      checkState(4, 3, 1, 1, 3, 1, 1, 0);
      applyStimulus(4'hF, 4'hF, 1'b0, 4'h0);
      checkState(4, 3, 1, 1, 3, 0, 1, 0);
      checkOutput("sb_empty", sb.size(), 0);
      active_b = 1'b0;

      $display("[TB] counter saturation");
      doReset();
      for (int i = 0; i < 20; i++) begin
         expectGrant(1);
         applyStimulus(4'b0010, 4'hF, 1'b0, 4'b0010);
         if (i == 14) checkState(15, 15, 0, 0, 0, 0, 0, 0);
      end
      checkState(15, 15, 0, 0, 0, 0, 0, 0);
      expectGrant(1);
      applyStimulus(4'b0010, 4'h0, 1'b0, 4'b0010);
      checkState(15, 15, 1, 1, 1, 0, 0, 0);
      checkOutput("sb_empty", sb.size(), 0);

      $display("[TB] drain with outstanding requesters");
      doReset();
      expectGrant(0); applyStimulus(4'b0011, 4'hF, 1'b0, 4'b0001);
      expectGrant(1); applyStimulus(4'b0011, 4'hF, 1'b0, 4'b0010);
      expectGrant(0); applyStimulus(4'b0011, 4'hF, 1'b1, 4'b0001);
      checkOutput("drain_done", 32'(done_a), 32'd0);
      expectGrant(1); applyStimulus(4'b0011, 4'hF, 1'b1, 4'b0010);
      expectGrant(0); applyStimulus(4'b0011, 4'b1110, 1'b1, 4'b0001);
      expectGrant(1); applyStimulus(4'b0011, 4'b1101, 1'b1, 4'b0010);
      checkState(6, 4, 2, 1, 0, 0, 0, 0);
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0);
      checkState(6, 4, 2, 1, 0, 1, 1, 0);
      checkOutput("sb_empty", sb.size(), 0);

      $display("[TB] reset while draining");
      doReset();
      for (int i = 0; i < 5; i++) begin
         expectGrant(2);
         applyStimulus(4'b0100, (i == 0) ? 4'b1011 : 4'hF, 1'b0, 4'b0100);
      end
      checkState(5, 4, 1, 1, 2, 0, 0, 0);
      applyStimulus(4'h0, 4'hF, 1'b1, 4'h0);
      checkState(5, 4, 1, 1, 2, 0, 0, 0);
      reset_a = 1'b1;
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0);
      reset_a = 1'b0;
      checkState(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0);
      checkState(0, 0, 0, 0, 0, 0, 0, 0);
      expectGrant(0);
      applyStimulus(4'hF, 4'hF, 1'b0, 4'b0001);
      checkState(1, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tb_assert_sched.md
# tb_assert_sched

Synthesizable check-result scheduler for the simulation environment. It shares one set of assertion counters among NREQ independent checkers, such as bus monitors, memory scoreboards and the CPU self-test port. Each checker presents a pass/fail result through a valid/ready handshake. The block grants one result per cycle round-robin, keeps saturating totals, sequences the end-of-test and die-on-fail flow, and raises a single finish request toward the testbench top.

## Interface
- NREQ, 4, number of checker requesters (2..16)
- CW, 16, width of each result counter
- DIE_ON_FAIL, 0, 1 = stop accepting results and finish on the first failed check
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; clears all state
- req_valid  in  NREQ  per-checker result valid
- req_pass  in  NREQ  per-checker result: 1 = pass, 0 = fail; meaningful only with valid
- req_ready  out  NREQ  one-hot grant; result accepted when valid & ready
- end_req  in  1  level or pulse; test body finished, drain outstanding results
- tot_cnt  out  CW  accepted results
- pass_cnt  out  CW  accepted passes
- fail_cnt  out  CW  accepted fails
- first_fail_vld  out  1  a fail has been accepted since reset
- first_fail_id  out  max(1,$clog2(NREQ))  index of the requester whose fail was accepted first
- finish_req  out  1  one-cycle pulse on entry to DONE
- done  out  1  high while in DONE
- verdict_ok  out  1  done & fail_cnt==0 & tot_cnt!=0

## Operation
- States: RUN (reset state), DRAIN, DONE.
- Arbitration in RUN and DRAIN:
  - Round-robin pointer ptr, reset value 0.
  - Grant goes to the first index at or after ptr (wrapping modulo NREQ) with req_valid=1.
  - req_ready is high for that index only; it is all-zero when no requester is valid, and in DONE.
  - After an accept, ptr becomes granted index+1, wrapping NREQ-1 to 0. With no accept, ptr holds.
- On accept:
  - tot_cnt increments.
  - pass_cnt or fail_cnt increments according to req_pass of the granted index.
  - Each counter saturates at 2^CW-1 and does not wrap. Saturation of one counter does not block the others.
- First fail: on the first accepted fail since reset, capture first_fail_id and set first_fail_vld. Later fails do not change either.
- Transitions:
  - RUN to DRAIN when end_req=1.
  - RUN to DONE when DIE_ON_FAIL=1 and a fail is accepted; this has priority over end_req in the same cycle.
  - DRAIN to DONE on the first cycle in which req_valid is all-zero. The DIE_ON_FAIL rule also applies in DRAIN.
  - DONE is terminal until reset.
- A result accepted in the same cycle that end_req rises, or that DIE triggers, is counted.
- DONE: counters, first_fail fields and verdict_ok hold; later req_valid is ignored and stays unacknowledged.
- Reset mid-operation clears counters, first_fail_vld, first_fail_id, ptr and state to RUN in the cycle it is sampled. No finish_req is generated by reset.

## Timing
- Reset values:
  - req_ready, all counters, first_fail_vld, first_fail_id, finish_req, done and verdict_ok are all 0.
  - State is RUN and ptr is 0.
- req_ready is combinational from state, ptr and req_valid (same cycle). No input-to-output path other than this.
- Counters, first_fail fields and ptr update on the clock edge that completes the handshake. They are visible one cycle after valid & ready.
- Throughput: one result per cycle total, regardless of NREQ.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- finish_req and done go high in the cycle after the DONE-causing condition. finish_req is exactly one cycle; done remains high.
- verdict_ok is registered with done.

## Test plan
- NREQ=4, all four valid and pass for 8 cycles, then end_req and all valid low -> grants 0,1,2,3,0,1,2,3; tot=8, pass=8, fail=0; finish_req pulses once; verdict_ok=1.
- Requester 2 fails once mid-stream, DIE_ON_FAIL=0, 10 results total -> fail_cnt=1, first_fail_id=2, first_fail_vld=1, verdict_ok=0 after drain.
- DIE_ON_FAIL=1, requester 3 fails in the cycle end_req rises -> fail counted, DONE next cycle, all req_ready low afterward, first_fail_id=3.
- CW=4, one requester always valid and passing for 20 cycles -> pass_cnt and tot_cnt stick at 15 with no wrap; fail_cnt=0.
- end_req with requesters 0 and 1 still valid for 3 more cycles -> DRAIN accepts 3 more results; done rises one cycle after the first all-idle cycle.
- reset asserted in DRAIN with counters at 5 -> next cycle all counters 0, state RUN, no finish_req pulse, and first_fail_vld=0.
